nap_time_setter: RTL and testbench

Parametrised successor of the nap-duration setting block. It holds an hh:mm:ss duration in an internal register and edits it from one-hot keypad presses with configurable step sizes. Both add and subtract modes are supported, with multi-cycle carry/borrow normalisation, saturation at a configurable hour ceiling, preload from the running time, and a commit pulse on `#`. It sits between the keypad decoder and the nap countdown timer, which samples the BCD outputs when `complete` pulses.

---
 rtl/nap_time_setter_if.sv | 24 ++
 rtl/nap_time_setter.sv | 205 ++++++++++++++++++++
 tb/tb_nap_time_setter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/nap_time_setter_if.sv
// Keypad/preload/BCD bundle between the keypad decoder side and the nap duration setter.
interface nap_time_setter_if;
    logic       en;
    logic [9:0] keypad;
    logic       sharp;
    logic       down;
    logic       load;
    logic [3:0] oHour10, oHour1, oMinute10, oMinute1, oSecond10, oSecond1;
    logic [3:0] hour10, hour1, minute10, minute1, second10, second1;
    logic       busy;
    logic       complete;

    modport master (
        output en, keypad, sharp, down, load,
        output oHour10, oHour1, oMinute10, oMinute1, oSecond10, oSecond1,
        input  hour10, hour1, minute10, minute1, second10, second1, busy, complete
    );

    modport slave (
        input  en, keypad, sharp, down, load,
        input  oHour10, oHour1, oMinute10, oMinute1, oSecond10, oSecond1,
        output hour10, hour1, minute10, minute1, second10, second1, busy, complete
    );
endinterface

// File: rtl/nap_time_setter.sv
// Holds an hh:mm:ss nap duration in binary, edits it from one-hot keypad steps with
// carry/borrow normalisation and saturation, and re-publishes it as BCD on return to IDLE.
module nap_time_setter #(
    parameter int HOUR_MAX   = 99,
    parameter int SEC_STEP_A = 5,
    parameter int SEC_STEP_B = 30,
    parameter int MIN_STEP_A = 1,
    parameter int MIN_STEP_B = 10,
    parameter int HOUR_STEP  = 1
) (
    input  logic clock,
    input  logic reset,
    nap_time_setter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, APPLY, CARRY_S, CARRY_M, CARRY_H} state_t;

    // 9-bit signed keeps hour + HOUR_STEP + carry clear of wrap for any legal HOUR_MAX
    localparam logic signed [8:0] HMAX = 9'(HOUR_MAX);
    localparam logic [8:0]        HMAX_U = 9'(HOUR_MAX);
    localparam logic signed [8:0] S_A = 9'(SEC_STEP_A);
    localparam logic signed [8:0] S_B = 9'(SEC_STEP_B);
    localparam logic signed [8:0] M_A = 9'(MIN_STEP_A);
    localparam logic signed [8:0] M_B = 9'(MIN_STEP_B);
    localparam logic signed [8:0] H_S = 9'(HOUR_STEP);

    state_t r_state, w_state_nxt;

    logic [9:0]        r_kp_prev;
    logic [5:0]        r_key;
    logic              r_load, r_sharp, r_down, r_sub;
    logic signed [8:0] r_ld_sec, r_ld_min, r_ld_hour;
    logic signed [8:0] r_sec, r_min, r_hour;
    logic signed [8:0] w_sec_nxt, w_min_nxt, w_hour_nxt;
    logic [1:0]        r_field, w_field;
    logic signed [8:0] r_step, w_step, w_delta;
    logic              r_busy, r_complete, w_complete;
    logic [3:0]        r_h10, r_h1, r_m10, r_m1, r_s10, r_s1;

    logic [9:0] w_rise;
    logic       w_onehot, w_key_ev, w_ld_bad;
    logic [8:0] w_ld_h, w_ld_m, w_ld_s;

    function automatic logic [7:0] to_bcd(input logic signed [8:0] v);
        logic [8:0] u;
        u = v;
        return {4'(u / 9'd10), 4'(u % 9'd10)};
    endfunction

    // An event needs a fresh rising line and a clean one-hot vector
    assign w_rise   = bus.keypad & ~r_kp_prev;
    assign w_onehot = (bus.keypad != '0) && ((bus.keypad & (bus.keypad - 10'd1)) == '0);
    assign w_key_ev = w_onehot && (w_rise == bus.keypad);

    assign w_ld_h   = 9'(bus.oHour10)   * 9'd10 + 9'(bus.oHour1);
    assign w_ld_m   = 9'(bus.oMinute10) * 9'd10 + 9'(bus.oMinute1);
    assign w_ld_s   = 9'(bus.oSecond10) * 9'd10 + 9'(bus.oSecond1);
    assign w_ld_bad = (bus.oHour10 > 4'd9) || (bus.oHour1 > 4'd9) || (bus.oMinute10 > 4'd5) ||
                      (bus.oMinute1 > 4'd9) || (bus.oSecond10 > 4'd5) || (bus.oSecond1 > 4'd9) ||
                      (w_ld_h > HMAX_U);

    always_comb begin
        w_field = 2'd0;
        w_step  = S_A;
        if (r_key[2]) begin
            w_step = S_B;
        end else if (r_key[3]) begin
            w_field = 2'd1;
            w_step  = M_A;
        end else if (r_key[4]) begin
            w_field = 2'd1;
            w_step  = M_B;
        end else if (r_key[5]) begin
            w_field = 2'd2;
            w_step  = H_S;
        end
    end

    assign w_delta = r_sub ? -r_step : r_step;

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sec_nxt   = r_sec;
        w_min_nxt   = r_min;
        w_hour_nxt  = r_hour;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_load) begin
                    w_sec_nxt  = r_ld_sec;
                    w_min_nxt  = r_ld_min;
                    w_hour_nxt = r_ld_hour;
                end else if (r_sharp) begin
                    w_complete = 1'b1;
                end else if (r_key[0]) begin
                    w_sec_nxt  = '0;
                    w_min_nxt  = '0;
                    w_hour_nxt = '0;
                end else if (|r_key[5:1]) begin
                    w_state_nxt = APPLY;
                end
            end
            APPLY: begin
                case (r_field)
                    2'd0:    w_sec_nxt  = r_sec + w_delta;
                    2'd1:    w_min_nxt  = r_min + w_delta;
                    default: w_hour_nxt = r_hour + w_delta;
                endcase
                w_state_nxt = CARRY_S;
            end
            CARRY_S: begin
                if (r_sec >= 9'sd60) begin
                    w_sec_nxt = r_sec - 9'sd60;
                    w_min_nxt = r_min + 9'sd1;
                end else if (r_sec < 9'sd0) begin
                    w_sec_nxt = r_sec + 9'sd60;
                    w_min_nxt = r_min - 9'sd1;
                end
                w_state_nxt = CARRY_M;
            end
            CARRY_M: begin
                if (r_min >= 9'sd60) begin
                    w_min_nxt  = r_min - 9'sd60;
                    w_hour_nxt = r_hour + 9'sd1;
                end else if (r_min < 9'sd0) begin
                    w_min_nxt  = r_min + 9'sd60;
                    w_hour_nxt = r_hour - 9'sd1;
                end
                w_state_nxt = CARRY_H;
            end
            CARRY_H: begin
                if (r_hour > HMAX) begin
                    w_hour_nxt = HMAX;
                    w_min_nxt  = 9'sd59;
                    w_sec_nxt  = 9'sd59;
                end else if (r_hour < 9'sd0) begin
                    w_hour_nxt = '0;
                    w_min_nxt  = '0;
                    w_sec_nxt  = '0;
                end
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_kp_prev  <= '0;
            r_key      <= '0;
            r_load     <= 1'b0;
            r_sharp    <= 1'b0;
            r_down     <= 1'b0;
            r_ld_sec   <= '0;
            r_ld_min   <= '0;
            r_ld_hour  <= '0;
            r_sec      <= '0;
            r_min      <= '0;
            r_hour     <= '0;
            r_field    <= '0;
            r_step     <= '0;
            r_sub      <= 1'b0;
            r_busy     <= 1'b0;
            r_complete <= 1'b0;
            {r_h10, r_h1, r_m10, r_m1, r_s10, r_s1} <= '0;
        end else begin
            r_kp_prev  <= bus.keypad;
            r_key      <= (bus.en && w_key_ev) ? bus.keypad[5:0] : 6'd0;
            r_load     <= bus.en & bus.load;
            r_sharp    <= bus.en & bus.sharp;
            r_down     <= bus.down;
            r_ld_sec   <= w_ld_bad ? 9'sd59 : $signed(w_ld_s);
            r_ld_min   <= w_ld_bad ? 9'sd59 : $signed(w_ld_m);
            r_ld_hour  <= w_ld_bad ? HMAX   : $signed(w_ld_h);
            r_sec      <= w_sec_nxt;
            r_min      <= w_min_nxt;
            r_hour     <= w_hour_nxt;
            if (r_state == IDLE) begin
                r_field <= w_field;
                r_step  <= w_step;
                r_sub   <= r_down;
            end
            r_busy     <= (w_state_nxt != IDLE);
            r_complete <= w_complete;
            // Leaving CARRY_H publishes the normalised value directly so it lands with busy falling
            if (r_state == IDLE)
                {r_h10, r_h1, r_m10, r_m1, r_s10, r_s1} <= {to_bcd(r_hour), to_bcd(r_min), to_bcd(r_sec)};
            else if (r_state == CARRY_H)
                {r_h10, r_h1, r_m10, r_m1, r_s10, r_s1} <= {to_bcd(w_hour_nxt), to_bcd(w_min_nxt), to_bcd(w_sec_nxt)};
        end
    end

    assign bus.hour10   = r_h10;
    assign bus.hour1    = r_h1;
    assign bus.minute10 = r_m10;
    assign bus.minute1  = r_m1;
    assign bus.second10 = r_s10;
    assign bus.second1  = r_s1;
    assign bus.busy     = r_busy;
    assign bus.complete = r_complete;
endmodule

// File: tb/tb_nap_time_setter.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor compares them.
module tb_nap_time_setter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nap_time_setter_if bus();

    nap_time_setter #(
        .HOUR_MAX(23), .SEC_STEP_A(5), .SEC_STEP_B(30),
        .MIN_STEP_A(1), .MIN_STEP_B(10), .HOUR_STEP(1)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    typedef struct {
        int          due;
        string       nm;
        logic [23:0] bcd;
        logic        busy;
        logic        cmp;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   flush  = 1'b0;
    logic [23:0] got;

    assign got = {bus.hour10, bus.hour1, bus.minute10, bus.minute1, bus.second10, bus.second1};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() != 0 && q[0].due <= cyc) begin
            cur = q.pop_front();
            n_vec++;
            if (cur.due != cyc || got !== cur.bcd || bus.busy !== cur.busy || bus.complete !== cur.cmp) begin
                n_miss++;
                $display("FAIL %s @%0d: got bcd=%h busy=%b complete=%b, need bcd=%h busy=%b complete=%b",
                         cur.nm, cyc, got, bus.busy, bus.complete, cur.bcd, cur.busy, cur.cmp);
            end
        end
        if (flush) begin
            while (q.size() != 0) begin
                cur = q.pop_front();
                n_vec++;
                n_miss++;
                $display("FAIL %s: expectation at cycle %0d never compared (now %0d)", cur.nm, cur.due, cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input int due, input string nm, input logic [23:0] b, input logic bz, input logic c);
        exp_t e;
        e.due = due; e.nm = nm; e.bcd = b; e.busy = bz; e.cmp = c;
        q.push_back(e);
    endtask

    task automatic pulse(input logic [9:0] kp, input logic sh, input logic ld, input logic dn);
        bus.keypad = kp; bus.sharp = sh; bus.load = ld; bus.down = dn;
        tick(1);
        bus.keypad = '0; bus.sharp = 1'b0; bus.load = 1'b0; bus.down = 1'b0;
    endtask

    task automatic key_edit(input string nm, input int key, input logic dn,
                            input logic [23:0] pre, input logic [23:0] post);
        int k;
        k = cyc;
        chk(k + 1, {nm, "_accept"}, pre, 1'b0, 1'b0);
        for (int i = 2; i <= 5; i++) chk(k + i, {nm, "_busy"}, pre, 1'b1, 1'b0);
        chk(k + 6, nm, post, 1'b0, 1'b0);
        pulse(10'(1 << key), 1'b0, 1'b0, dn);
        tick(6);
    endtask

    task automatic load_val(input string nm, input logic [23:0] dig, input logic [23:0] post);
        int k;
        k = cyc;
        chk(k + 3, nm, post, 1'b0, 1'b0);
        {bus.oHour10, bus.oHour1, bus.oMinute10, bus.oMinute1, bus.oSecond10, bus.oSecond1} = dig;
        pulse('0, 1'b0, 1'b1, 1'b0);
        tick(3);
    endtask

    task automatic clear_key0(input string nm);
        int k;
        k = cyc;
        chk(k + 3, nm, 24'h000000, 1'b0, 1'b0);
        pulse(10'h001, 1'b0, 1'b0, 1'b0);
        tick(3);
    endtask

    task automatic idle_chk(input string nm, input logic [9:0] kp, input logic [23:0] held, input logic en);
        int k;
        k = cyc;
        for (int i = 2; i <= 7; i++) chk(k + i, nm, held, 1'b0, 1'b0);
        bus.en = en;
        pulse(kp, 1'b0, 1'b0, 1'b0);
        tick(7);
        bus.en = 1'b1;
    endtask

    initial begin
        int k;
        bus.en = 1'b1; bus.keypad = '0; bus.sharp = 1'b0; bus.down = 1'b0; bus.load = 1'b0;
        {bus.oHour10, bus.oHour1, bus.oMinute10, bus.oMinute1, bus.oSecond10, bus.oSecond1} = '0;
        tick(3);
        rst = 1'b0;
        chk(cyc, "reset", 24'h000000, 1'b0, 1'b0);
        tick(2);

        key_edit("k1_add", 1, 1'b0, 24'h000000, 24'h000005);
        load_val("ld_005958", 24'h005958, 24'h005958);
        key_edit("k2_carry", 2, 1'b0, 24'h005958, 24'h010028);

        k = cyc;
        chk(k + 2, "sharp_pulse", 24'h010028, 1'b0, 1'b1);
        chk(k + 3, "sharp_end", 24'h010028, 1'b0, 1'b0);
        pulse('0, 1'b1, 1'b0, 1'b0);
        tick(3);

        load_val("ld_235940", 24'h235940, 24'h235940);
        key_edit("k2_sat", 2, 1'b0, 24'h235940, 24'h235959);
        load_val("ld_000003", 24'h000003, 24'h000003);
        key_edit("k1_floor", 1, 1'b1, 24'h000003, 24'h000000);
        load_val("ld_010000", 24'h010000, 24'h010000);
        key_edit("k3_borrow", 3, 1'b1, 24'h010000, 24'h005900);
        load_val("ld_bad_m10", 24'h127000, 24'h235959);
        clear_key0("k0_clear");
        load_val("ld_hour_over", 24'h240000, 24'h235959);
        key_edit("k5_sub", 5, 1'b1, 24'h235959, 24'h225959);
        clear_key0("k0_clear2");

        // second key 3 lands while the first edit is still normalising
        k = cyc;
        chk(k + 6, "drop_first", 24'h000100, 1'b0, 1'b0);
        chk(k + 9, "drop_second", 24'h000100, 1'b0, 1'b0);
        pulse(10'h008, 1'b0, 1'b0, 1'b0);
        tick(1);
        pulse(10'h008, 1'b0, 1'b0, 1'b0);
        tick(7);

        idle_chk("multi_hot", 10'b0000000110, 24'h000100, 1'b1);
        idle_chk("key7", 10'h080, 24'h000100, 1'b1);
        idle_chk("en_low", 10'h002, 24'h000100, 1'b0);

        k = cyc;
        chk(k + 6, "held_once", 24'h000105, 1'b0, 1'b0);
        chk(k + 10, "held_still", 24'h000105, 1'b0, 1'b0);
        bus.keypad = 10'h002;
        tick(10);
        bus.keypad = '0;
        tick(1);

        k = cyc;
        chk(k + 4, "rst_pre", 24'h000105, 1'b1, 1'b0);
        pulse(10'h010, 1'b0, 1'b0, 1'b0);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk(k + 5, "rst_mid", 24'h000000, 1'b0, 1'b0);
        chk(k + 7, "rst_idle", 24'h000000, 1'b0, 1'b0);
        tick(3);

        key_edit("post_rst", 1, 1'b0, 24'h000000, 24'h000005);

        for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
        flush = 1'b1;
        tick(1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
